// File: rtl/gcd_requester_if.sv
// Handshake bundle between gcd_requester and its environment.
// Carries the upstream operand stream (req_*), the GCD unit operand and result
// channels (ops_*, res_*), the downstream result record (out_*) and the
// done_cnt/err status.
//   master : requester side (drives req_rdy, ops_*, res_rdy, out_*, done_cnt, err)
//   slave  : environment side (source, GCD unit and sink)
interface gcd_requester_if #(
  parameter int unsigned WL   = 8,
  parameter int unsigned TAGW = 8
);
  logic            req_val;
  logic            req_rdy;
  logic [WL-1:0]   req_a;
  logic [WL-1:0]   req_b;
  logic            ops_val;
  logic            ops_rdy;
  logic [WL-1:0]   ops_a;
  logic [WL-1:0]   ops_b;
  logic            res_val;
  logic            res_rdy;
  logic [WL-1:0]   res_data;
  logic            out_val;
  logic            out_rdy;
  logic [WL-1:0]   out_a;
  logic [WL-1:0]   out_b;
  logic [WL-1:0]   out_gcd;
  logic [TAGW-1:0] out_tag;
  logic [15:0]     done_cnt;
  logic            err;

  modport master (
    input  req_val, req_a, req_b, ops_rdy, res_val, res_data, out_rdy,
    output req_rdy, ops_val, ops_a, ops_b, res_rdy,
           out_val, out_a, out_b, out_gcd, out_tag, done_cnt, err
  );

  modport slave (
    output req_val, req_a, req_b, ops_rdy, res_val, res_data, out_rdy,
    input  req_rdy, ops_val, ops_a, ops_b, res_rdy,
           out_val, out_a, out_b, out_gcd, out_tag, done_cnt, err
  );
endinterface

// File: rtl/gcd_requester.sv
// Initiator for a GCD compute unit. Operand pairs from upstream are queued in a
// DEPTH-entry FIFO, issued one at a time over ops_val/ops_rdy, and each result
// (res_val/res_rdy) is returned downstream as a record {a, b, gcd, tag}.
// Pairs with a zero operand are answered locally (gcd = a | b) without a GCD
// transaction. A sticky err flag sets after TMO cycles waiting for a result.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : gcd_requester_if.master (req_*, ops_*, res_*, out_*, done_cnt, err)
module gcd_requester #(
  parameter int unsigned WL    = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAGW  = 8,
  parameter int unsigned TMO   = 1024
) (
  input  logic            clk,
  input  logic            rst,
  gcd_requester_if.master bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(TMO + 1);
  localparam logic [CW-1:0] TmoMax  = CW'(TMO);
  localparam logic [CW-1:0] TmoLast = CW'(TMO - 1);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e          state_q;
  logic [AW:0]     wr_ptr_q, rd_ptr_q;
  logic [WL-1:0]   mem_a [DEPTH];
  logic [WL-1:0]   mem_b [DEPTH];
  logic [WL-1:0]   hold_a_q, hold_b_q;
  logic [TAGW-1:0] hold_tag_q, tag_q;
  logic [CW-1:0]   wait_cnt_q;
  logic            out_val_q;
  logic [WL-1:0]   out_a_q, out_b_q, out_gcd_q;
  logic [TAGW-1:0] out_tag_q;
  logic [15:0]     done_cnt_q;
  logic            err_q;

  logic          full, empty, head_zero, slot_free;
  logic          push, issue, bypass, pop, res_fire, out_fire;
  logic [WL-1:0] head_a, head_b;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head_a    = mem_a[rd_ptr_q[AW-1:0]];
  assign head_b    = mem_b[rd_ptr_q[AW-1:0]];
  assign head_zero = (head_a == '0) || (head_b == '0);
  assign slot_free = !out_val_q || bus.out_rdy;

  assign bus.req_rdy = !full;
  assign bus.ops_val = (state_q == StIdle) && !empty && !head_zero;
  assign bus.ops_a   = head_a;
  assign bus.ops_b   = head_b;
  assign bus.res_rdy = (state_q == StWait) && slot_free;

  assign push     = bus.req_val && !full;
  assign issue    = bus.ops_val && bus.ops_rdy;
  assign bypass   = (state_q == StIdle) && !empty && head_zero && slot_free;
  assign pop      = issue || bypass;
  assign res_fire = bus.res_val && bus.res_rdy;
  assign out_fire = out_val_q && bus.out_rdy;

  assign bus.out_val  = out_val_q;
  assign bus.out_a    = out_a_q;
  assign bus.out_b    = out_b_q;
  assign bus.out_gcd  = out_gcd_q;
  assign bus.out_tag  = out_tag_q;
  assign bus.done_cnt = done_cnt_q;
  assign bus.err      = err_q;

  // Storage carries no reset: only the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr_q[AW-1:0]] <= bus.req_a;
      mem_b[wr_ptr_q[AW-1:0]] <= bus.req_b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      hold_a_q   <= '0;
      hold_b_q   <= '0;
      hold_tag_q <= '0;
      tag_q      <= '0;
      wait_cnt_q <= '0;
      out_val_q  <= 1'b0;
      out_a_q    <= '0;
      out_b_q    <= '0;
      out_gcd_q  <= '0;
      out_tag_q  <= '0;
      done_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);

      if (out_fire) begin
        out_val_q  <= 1'b0;
        done_cnt_q <= done_cnt_q + 16'd1;
      end

      // A reload below overrides the clear above in the same cycle.
      unique case (state_q)
        StIdle: begin
          if (issue) begin
            hold_a_q   <= head_a;
            hold_b_q   <= head_b;
            hold_tag_q <= tag_q;
            tag_q      <= tag_q + TAGW'(1);
            wait_cnt_q <= '0;
            state_q    <= StWait;
          end else if (bypass) begin
            out_val_q <= 1'b1;
            out_a_q   <= head_a;
            out_b_q   <= head_b;
            out_gcd_q <= head_a | head_b;
            out_tag_q <= tag_q;
            tag_q     <= tag_q + TAGW'(1);
          end
        end
        StWait: begin
          // Counter saturates at TMO; err is sticky until reset.
          if (wait_cnt_q != TmoMax) wait_cnt_q <= wait_cnt_q + CW'(1);
          if (wait_cnt_q == TmoLast) err_q <= 1'b1;
          if (res_fire) begin
            out_val_q <= 1'b1;
            out_a_q   <= hold_a_q;
            out_b_q   <= hold_b_q;
            out_gcd_q <= bus.res_data;
            out_tag_q <= hold_tag_q;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_requester.sv
// Self-checking bench for gcd_requester: queue-based reference model compared
// every cycle, a simple GCD unit responder, and directed scenarios with literal
// expectations.
module tb_gcd_requester;
  localparam int unsigned WL    = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned TAGW  = 8;
  localparam int unsigned TMO   = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gcd_requester_if #(.WL(WL), .TAGW(TAGW)) bus ();

  gcd_requester #(.WL(WL), .DEPTH(DEPTH), .TAGW(TAGW), .TMO(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned gcd_f(input int unsigned a, input int unsigned b);
    int unsigned t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // ---------------- reference model ----------------
  int unsigned qa[$], qb[$];
  bit          m_wait, m_out_val, m_err;
  int unsigned m_hold_a, m_hold_b, m_hold_tag;
  int unsigned m_out_a, m_out_b, m_out_gcd, m_out_tag;
  int unsigned m_tag, m_done, m_wcyc;

  always @(posedge clk or posedge rst) begin : model
    bit ne, hz, sf, psh;
    if (rst) begin
      qa.delete();
      qb.delete();
      m_wait = 0; m_out_val = 0; m_err = 0;
      m_tag = 0; m_done = 0; m_wcyc = 0;
      m_out_a = 0; m_out_b = 0; m_out_gcd = 0; m_out_tag = 0;
    end else begin
      ne  = qa.size() != 0;
      hz  = ne && (qa[0] == 0 || qb[0] == 0);
      sf  = !m_out_val || bus.out_rdy;
      psh = bus.req_val && (qa.size() < DEPTH);
      if (m_out_val && bus.out_rdy) begin
        m_out_val = 0;
        m_done    = (m_done + 1) % 65536;
      end
      if (!m_wait) begin
        if (ne && !hz && bus.ops_rdy) begin
          m_hold_a = qa.pop_front();
          m_hold_b = qb.pop_front();
          m_hold_tag = m_tag;
          m_tag  = (m_tag + 1) % (2 ** TAGW);
          m_wait = 1;
          m_wcyc = 0;
        end else if (ne && hz && sf) begin
          m_out_a   = qa.pop_front();
          m_out_b   = qb.pop_front();
          m_out_gcd = gcd_f(m_out_a, m_out_b);
          m_out_tag = m_tag;
          m_out_val = 1;
          m_tag     = (m_tag + 1) % (2 ** TAGW);
        end
      end else begin
        m_wcyc++;
        if (m_wcyc >= TMO) m_err = 1;
        if (bus.res_val && sf) begin
          m_out_a   = m_hold_a;
          m_out_b   = m_hold_b;
          m_out_gcd = bus.res_data;
          m_out_tag = m_hold_tag;
          m_out_val = 1;
          m_wait    = 0;
        end
      end
      if (psh) begin
        qa.push_back(bus.req_a);
        qb.push_back(bus.req_b);
      end
    end
  end

  always @(negedge clk) begin : compare
    bit ne, hz, exp_ops;
    if (!rst) begin
      ne      = qa.size() != 0;
      hz      = ne && (qa[0] == 0 || qb[0] == 0);
      exp_ops = !m_wait && ne && !hz;
      check("req_rdy", bus.req_rdy, qa.size() < DEPTH);
      check("ops_val", bus.ops_val, exp_ops);
      if (exp_ops) begin
        check("ops_a", bus.ops_a, qa[0]);
        check("ops_b", bus.ops_b, qb[0]);
      end
      check("res_rdy", bus.res_rdy, m_wait && (!m_out_val || bus.out_rdy));
      check("out_val", bus.out_val, m_out_val);
      if (m_out_val) begin
        check("out_a", bus.out_a, m_out_a);
        check("out_b", bus.out_b, m_out_b);
        check("out_gcd", bus.out_gcd, m_out_gcd);
        check("out_tag", bus.out_tag, m_out_tag);
      end
      check("done_cnt", bus.done_cnt, m_done);
      check("err", bus.err, m_err);
    end
  end

  // ---------------- GCD unit responder ----------------
  bit          resp_en    = 1;
  int          resp_delay = 1;
  bit          pend;
  int          pcnt;
  logic [WL-1:0] pdata;

  initial begin : unit
    bus.res_val  = 1'b0;
    bus.res_data = '0;
    pend = 0;
    forever begin
      bit of, rf;
      logic [WL-1:0] oa, ob;
      @(negedge clk);
      of = bus.ops_val && bus.ops_rdy;
      rf = bus.res_val && bus.res_rdy;
      oa = bus.ops_a;
      ob = bus.ops_b;
      @(posedge clk);
      #1;
      if (rst) begin
        bus.res_val = 1'b0;
        pend = 0;
      end else begin
        if (rf) bus.res_val = 1'b0;
        if (of) begin
          pend  = 1;
          pdata = WL'(gcd_f(oa, ob));
          pcnt  = resp_delay;
        end
        if (pend && !bus.res_val && resp_en) begin
          if (pcnt == 0) begin
            bus.res_val  = 1'b1;
            bus.res_data = pdata;
            pend = 0;
          end else begin
            pcnt--;
          end
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic push(input logic [WL-1:0] a, input logic [WL-1:0] b);
    int n = 0;
    bus.req_val = 1'b1;
    bus.req_a   = a;
    bus.req_b   = b;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.req_rdy && n < 50);
    check("push_accept", bus.req_rdy, 1);
    @(posedge clk);
    #1;
    bus.req_val = 1'b0;
  endtask

  task automatic wait_out(input string name, input int maxc);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.out_val && n < maxc);
    check(name, bus.out_val, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  int exp_g[4] = '{6, 7, 4, 1};

  initial begin : main
    rst         = 1'b1;
    bus.req_val = 1'b0;
    bus.req_a   = '0;
    bus.req_b   = '0;
    bus.ops_rdy = 1'b0;
    bus.out_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_req_rdy", bus.req_rdy, 1);
    check("rst_ops_val", bus.ops_val, 0);
    check("rst_res_rdy", bus.res_rdy, 0);
    check("rst_out_val", bus.out_val, 0);
    check("rst_done_cnt", bus.done_cnt, 0);
    check("rst_err", bus.err, 0);
    @(posedge clk);
    #1;

    // Basic non-trivial pair
    bus.ops_rdy = 1'b1;
    resp_delay  = 1;
    push(8'd12, 8'd18);
    @(negedge clk);
    check("t1_ops_val", bus.ops_val, 1);
    check("t1_ops_a", bus.ops_a, 12);
    check("t1_ops_b", bus.ops_b, 18);
    wait_out("t1_out_timeout", 50);
    check("t1_out_a", bus.out_a, 12);
    check("t1_out_b", bus.out_b, 18);
    check("t1_out_gcd", bus.out_gcd, 6);
    check("t1_out_tag", bus.out_tag, 0);
    @(negedge clk);
    check("t1_done_cnt", bus.done_cnt, 1);

    // Zero-operand bypass
    do_reset();
    push(8'd0, 8'd7);
    push(8'd9, 8'd0);
    @(negedge clk);
    check("t2_out_val0", bus.out_val, 1);
    check("t2_gcd0", bus.out_gcd, 7);
    check("t2_tag0", bus.out_tag, 0);
    @(negedge clk);
    check("t2_out_val1", bus.out_val, 1);
    check("t2_gcd1", bus.out_gcd, 9);
    check("t2_tag1", bus.out_tag, 1);
    @(posedge clk);
    #1;

    // FIFO fill with the unit not ready, then drain in order
    do_reset();
    bus.ops_rdy = 1'b0;
    push(8'd12, 8'd18);
    push(8'd35, 8'd21);
    push(8'd8, 8'd12);
    push(8'd17, 8'd5);
    @(negedge clk);
    check("t3_full_rdy", bus.req_rdy, 0);
    @(posedge clk);
    #1;
    bus.req_val = 1'b1;
    bus.req_a   = 8'd7;
    bus.req_b   = 8'd7;
    repeat (3) begin
      @(negedge clk);
      check("t3_fifth_rdy", bus.req_rdy, 0);
    end
    @(posedge clk);
    #1;
    bus.req_val = 1'b0;
    bus.ops_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_out("t3_out_timeout", 50);
      check("t3_tag", bus.out_tag, i);
      check("t3_gcd", bus.out_gcd, exp_g[i]);
    end
    @(negedge clk);
    check("t3_done_cnt", bus.done_cnt, 4);
    @(posedge clk);
    #1;

    // Result back-pressure from a stalled output slot
    do_reset();
    bus.out_rdy = 1'b0;
    resp_delay  = 0;
    push(8'd12, 8'd18);
    push(8'd20, 8'd30);
    wait_out("t4_out_timeout", 50);
    check("t4_first_gcd", bus.out_gcd, 6);
    repeat (6) begin
      @(negedge clk);
      check("t4_res_rdy_low", bus.res_rdy, 0);
      check("t4_hold_gcd", bus.out_gcd, 6);
      check("t4_hold_tag", bus.out_tag, 0);
    end
    @(posedge clk);
    #1;
    bus.out_rdy = 1'b1;
    @(negedge clk);
    check("t4_res_rdy_high", bus.res_rdy, 1);
    @(negedge clk);
    check("t4_out_val2", bus.out_val, 1);
    check("t4_gcd2", bus.out_gcd, 10);
    check("t4_tag2", bus.out_tag, 1);
    check("t4_done1", bus.done_cnt, 1);
    @(negedge clk);
    check("t4_out_val_clr", bus.out_val, 0);
    check("t4_done2", bus.done_cnt, 2);
    @(posedge clk);
    #1;

    // Timeout: err after TMO cycles in WAIT, late result still delivered
    do_reset();
    resp_en = 0;
    push(8'd12, 8'd18);
    @(negedge clk);
    check("t5_ops_val", bus.ops_val, 1);
    @(posedge clk);
    repeat (15) @(posedge clk);
    @(negedge clk);
    check("t5_err_before", bus.err, 0);
    @(negedge clk);
    check("t5_err_after", bus.err, 1);
    repeat (5) @(posedge clk);
    #1;
    resp_en = 1;
    wait_out("t5_out_timeout", 50);
    check("t5_late_gcd", bus.out_gcd, 6);
    check("t5_late_tag", bus.out_tag, 0);
    check("t5_err_sticky", bus.err, 1);
    @(posedge clk);
    #1;

    // Reset while waiting with pairs queued
    resp_en = 0;
    push(8'd12, 8'd18);
    push(8'd35, 8'd21);
    push(8'd8, 8'd12);
    @(negedge clk);
    check("t6_waiting", bus.res_rdy, 1);
    #1;
    rst = 1'b1;
    #1;
    check("t6_req_rdy", bus.req_rdy, 1);
    check("t6_ops_val", bus.ops_val, 0);
    check("t6_res_rdy", bus.res_rdy, 0);
    check("t6_out_val", bus.out_val, 0);
    check("t6_done_cnt", bus.done_cnt, 0);
    check("t6_err", bus.err, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    resp_en = 1;
    push(8'd0, 8'd5);
    wait_out("t6_out_timeout", 50);
    check("t6_tag_restart", bus.out_tag, 0);
    check("t6_gcd", bus.out_gcd, 5);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
